// File: rtl/lut_arb_pkg.sv
// Shared types and helpers for the LUT access arbiter.
package lut_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOOKUP = 1'b1} state_t;

  localparam int NREQ_D = 4;
  localparam int W_D    = 2;

  // Wide enough for the largest supported requester count (8); callers truncate.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/lut_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // NREQ is a power of two, so IW-bit addition wraps modulo NREQ for free.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IW'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/lut_access_arbiter.sv
// Round-robin time-sharing of one reprogrammable lookup table among NREQ requesters.
module lut_access_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int W    = W_D,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  input  logic              cfg_we,
  input  logic [W-1:0]      cfg_addr,
  input  logic [W-1:0]      cfg_data
);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [W-1:0]    op_q, op_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [W-1:0]    lut_q [2**W];
  logic [W-1:0]    lut_d [2**W];

  logic            win_any;
  logic [IW-1:0]   win_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  // Lookups read lut_q, so a write landing on the same edge is seen only by later lookups.
  always_comb begin
    lut_d = lut_q;
    if (cfg_we) lut_d[cfg_addr] = cfg_data;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d   = NREQ'(onehot(3'(win_idx)));
          id_d    = win_idx;
          op_d    = req_in[int'(win_idx)*W +: W];
          ptr_d   = win_idx + IW'(1);
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        rsp_data_d  = lut_q[op_q];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < 2**W; i++) lut_q[i] <= W'(i);
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      lut_q       <= lut_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q == LOOKUP);

endmodule
